pl_stage_reg_elastic: RTL and testbench

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries one generic data bundle and one control bundle between any two pipeline stages. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction. It adds a synchronous flush that inserts bubbles and masks control outputs, so an invalid slot can never assert RegWrite or MemWrite downstream.

---
 rtl/pl_stage_reg_elastic.sv | 123 ++++++++++++
 tb/tb_pl_stage_reg_elastic.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pl_stage_reg_elastic.sv
// ---------------------------------------------------------------------------
// pl_stage_reg_elastic
//
// Elastic inter-stage pipeline register. It carries a generic data bundle and
// a control bundle between two pipeline stages. A 2-entry skid buffer (main
// and skid) means back-pressure never drops or duplicates an instruction. A
// synchronous flush turns every held slot into a bubble.
//
// Handshake (valid/ready): a transfer happens on a rising edge when valid and
// ready are both 1 in the same cycle. A producer holding valid=1 keeps its
// payload stable until the transfer. in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   upstream slot holds a real instruction
//   in_ready   stage can accept this cycle (skid entry empty)
//   in_data    upstream data payload   [DATA_W]
//   in_ctrl    upstream control payload [CTRL_W]
//   out_valid  output slot holds a real instruction (main entry valid)
//   out_ready  downstream accepts this cycle
//   out_data   main entry data
//   out_ctrl   main entry control, forced to 0 while out_valid=0
//   flush      synchronous kill of all held and incoming contents
//   occupancy  number of held entries (0..2), also serves as debug state
// ---------------------------------------------------------------------------
module pl_stage_reg_elastic #(
  parameter int unsigned DATA_W     = 160,
  parameter int unsigned CTRL_W     = 9,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_accept;
  logic w_drain;

  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = r_main_valid & out_ready;

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  // Invalid slots must never present RegWrite/MemWrite downstream.
  assign out_ctrl  = r_main_ctrl & {CTRL_W{r_main_valid}};
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (flush) begin
      // Flush discards held entries plus any same-cycle accept and drain.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end
    end else if (!r_main_valid) begin
      // Empty stage: the skid is necessarily empty too.
      if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
        r_main_ctrl  <= in_ctrl;
      end
    end else if (w_drain) begin
      if (r_skid_valid) begin
        // Skid advances into main. in_ready is 0 here, so the accept branch
        // is kept only for completeness of the rule.
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
        if (w_accept) begin
          r_skid_data <= in_data;
          r_skid_ctrl <= in_ctrl;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is stalled: park the incoming word in the skid entry.
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_skid_ctrl  <= in_ctrl;
    end
  end

  // The skid only ever fills behind a valid main entry.
  a_skid_behind_main : assert property (
    @(posedge clk) disable iff (!reset) !(r_skid_valid && !r_main_valid)
  );

endmodule

// File: tb/tb_pl_stage_reg_elastic.sv
module tb_pl_stage_reg_elastic;

  localparam int DATA_W = 160;
  localparam int CTRL_W = 9;
  localparam int ENT_W  = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the ordered list of entries the stage currently holds.
  logic [ENT_W-1:0] exp_q[$];

  pl_stage_reg_elastic #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .occupancy(occupancy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic m_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic [DATA_W-1:0] m_data();
    logic [ENT_W-1:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[ENT_W-1:CTRL_W];
  endfunction

  function automatic logic [CTRL_W-1:0] m_ctrl();
    logic [ENT_W-1:0] e;
    if (exp_q.size() == 0) return '0;
    e = exp_q[0];
    return e[CTRL_W-1:0];
  endfunction

  function automatic logic [1:0] m_occ();
    return 2'(exp_q.size());
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of stimulus, advances past the rising edge and updates
  // the model. Returns 1 time unit after the edge so outputs are settled.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic r, input logic f);
    logic acc, drn;
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
    #1;
    acc = v && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({d, c});
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      d[7:0] = 8'(8'h10 + i);
      drive(1'b1, d, 9'h1FF, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_data[7:0] !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL stream_data[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_data[7:0], 8'(8'h10 + i));
      end
      n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occupancy, in_ready);
      end
      n_checks++; if (out_ctrl !== 9'h1FF) begin n_fail++; $display("FAIL stream_ctrl[%0d] got=%h exp=1ff", i, out_ctrl); end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain got v=%0b c=%h occ=%0d exp 0/0/0", out_valid, out_ctrl, occupancy);
    end
  endtask

  task automatic test_back_pressure();
    logic [DATA_W-1:0] a, b, c;
    a = DATA_W'(16'hAAAA); b = DATA_W'(16'hBBBB); c = DATA_W'(16'hCCCC);
    drive(1'b1, a, 9'h011, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_a got occ=%0d rdy=%0b exp occ=1 rdy=1", occupancy, in_ready);
    end
    drive(1'b1, b, 9'h022, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_after_b got occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy, in_ready);
    end
    drive(1'b1, c, 9'h033, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2 || out_data[15:0] !== 16'hAAAA) begin
      n_fail++; $display("FAIL bp_c_held got occ=%0d data=%h exp occ=2 data=aaaa", occupancy, out_data[15:0]);
    end
    drive(1'b1, c, 9'h033, 1'b1, 1'b0);
    n_checks++; if (out_data[15:0] !== 16'hBBBB || out_ctrl !== 9'h022 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bp_second got data=%h ctrl=%h occ=%0d exp bbbb/022/1", out_data[15:0], out_ctrl, occupancy);
    end
    drive(1'b1, c, 9'h033, 1'b1, 1'b0);
    n_checks++; if (out_data[15:0] !== 16'hCCCC || out_ctrl !== 9'h033 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bp_third got data=%h ctrl=%h occ=%0d exp cccc/033/1", out_data[15:0], out_ctrl, occupancy);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_no_dup got v=%0b occ=%0d exp 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_full();
    drive(1'b1, rand_data(), 9'h1FF, 1'b0, 1'b0);
    drive(1'b1, rand_data(), 9'h1FF, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_prefill got occ=%0d exp=2", occupancy); end
    drive(1'b1, DATA_W'(16'hDDDD), 9'h1FF, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state got v=%0b c=%h occ=%0d rdy=%0b exp 0/0/0/1", out_valid, out_ctrl, occupancy, in_ready);
    end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL flush_clear_data got=%h exp=0", out_data); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b0 || out_data[15:0] === 16'hDDDD) begin
        n_fail++; $display("FAIL flush_d_absent[%0d] got v=%0b data=%h exp v=0", i, out_valid, out_data[15:0]);
      end
    end
  endtask

  task automatic test_ctrl_mask();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, rand_data(), 9'h1FF, 1'($urandom_range(0, 1)), 1'b0);
      n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
        n_fail++; $display("FAIL ctrl_mask[%0d] got v=%0b c=%h d=%h exp 0/0/0", i, out_valid, out_ctrl, out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] e;
    drive(1'b1, rand_data(), 9'h1FF, 1'b0, 1'b0);
    drive(1'b1, rand_data(), 9'h1FF, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL arst_prefill got occ=%0d exp=2", occupancy); end
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_immediate got v=%0b d=%h c=%h occ=%0d rdy=%0b exp 0/0/0/0/1",
                         out_valid, out_data, out_ctrl, occupancy, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    e = rand_data();
    drive(1'b1, e, 9'h0A5, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== e || out_ctrl !== 9'h0A5) begin
      n_fail++; $display("FAIL arst_first_accept got v=%0b d=%h c=%h exp 1/%h/0a5", out_valid, out_data, out_ctrl, e);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic f;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 3) != 0), rand_data(), 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 2) != 0), f);
      n_checks++; if (out_valid !== m_valid() || occupancy !== m_occ() || in_ready !== (m_occ() < 2)) begin
        n_fail++; $display("FAIL rand_state[%0d] got v=%0b occ=%0d rdy=%0b exp v=%0b occ=%0d", i,
                           out_valid, occupancy, in_ready, m_valid(), m_occ());
      end
      n_checks++; if (out_ctrl !== m_ctrl()) begin
        n_fail++; $display("FAIL rand_ctrl[%0d] got=%h exp=%h", i, out_ctrl, m_ctrl());
      end
      if (m_valid()) begin
        n_checks++; if (out_data !== m_data()) begin
          n_fail++; $display("FAIL rand_order[%0d] got=%h exp=%h", i, out_data, m_data());
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_ctrl_mask();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
